// File: rtl/branch_pattern_table.sv
`default_nettype none
// ============================================================================
// Module  : branch_pattern_table
// Purpose : Second-level table of 2-bit saturating counters for the local
//           two-level branch predictor. It also holds a saturating mispredict count.
// Rev     : 1.0  initial release
// ============================================================================
module branch_pattern_table #(
    parameter int         INDEX_WIDTH  = 5,
    parameter logic [1:0] COUNTER_INIT = 2'b01,
    parameter int         MISS_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] pred_index,
    output logic                   pred_taken,
    output logic [1:0]             pred_counter,
    output logic                   ready,
    input  logic                   res_valid,
    input  logic [INDEX_WIDTH-1:0] res_index,
    input  logic                   res_taken,
    input  logic                   res_predicted,
    output logic [MISS_WIDTH-1:0]  mispredicts
);

    localparam int                     DEPTH      = 1 << INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [INDEX_WIDTH-1:0] init_ptr;
    logic [1:0]             counters [DEPTH];

    logic                   pending_valid;
    logic [INDEX_WIDTH-1:0] pending_index;
    logic [1:0]             pending_value;

    logic                   res_accept;
    logic [1:0]             res_current;
    logic [1:0]             res_next;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (init_ptr == LAST_INDEX) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_ptr <= '0;
        end else if (state == ST_INIT) begin
            init_ptr <= init_ptr + 1'b1;
        end
    end

    assign ready = (state == ST_RUN);

    // ------------------------------------------------------------------
    // Resolve pipeline: read-modify in stage 1, array write in stage 2.
    // The bypass keeps back-to-back resolves to one index from losing an update.
    // ------------------------------------------------------------------
    assign res_accept  = ready && res_valid;
    assign res_current = (pending_valid && (pending_index == res_index))
                         ? pending_value : counters[res_index];

    always_comb begin
        res_next = res_current;
        if (res_taken) begin
            if (res_current != 2'b11) res_next = res_current + 2'd1;
        end else begin
            if (res_current != 2'b00) res_next = res_current - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_valid <= 1'b0;
            pending_index <= '0;
            pending_value <= 2'b00;
        end else begin
            pending_valid <= res_accept;
            if (res_accept) begin
                pending_index <= res_index;
                pending_value <= res_next;
            end
        end
    end

    // The array is not reset; the init sweep defines its contents.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            counters[init_ptr] <= COUNTER_INIT;
        end else if (pending_valid) begin
            counters[pending_index] <= pending_value;
        end
    end

    // ------------------------------------------------------------------
    // Mispredict counter, saturating at all-ones
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredicts <= '0;
        end else if (res_accept && (res_taken != res_predicted) && (mispredicts != '1)) begin
            mispredicts <= mispredicts + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    always_comb begin
        pred_counter = COUNTER_INIT;
        if (state == ST_RUN) begin
            if (pending_valid && (pending_index == pred_index)) begin
                pred_counter = pending_value;
            end else begin
                pred_counter = counters[pred_index];
            end
        end
    end

    assign pred_taken = pred_counter[1];

endmodule
`default_nettype wire

// File: tb/tb_branch_pattern_table.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_pattern_table
// Purpose : Directed vector bench for branch_pattern_table.
// Rev     : 1.0  initial release
// ============================================================================
module tb_branch_pattern_table;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  pred_index = '0;
    logic        pred_taken;
    logic [1:0]  pred_counter;
    logic        ready;
    logic        res_valid = 1'b0;
    logic [4:0]  res_index = '0;
    logic        res_taken = 1'b0;
    logic        res_predicted = 1'b0;
    logic [15:0] mispredicts;

    int n_tests = 0;
    int n_fail  = 0;

    branch_pattern_table #(
        .INDEX_WIDTH (5),
        .COUNTER_INIT(2'b01),
        .MISS_WIDTH  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pred_index   (pred_index),
        .pred_taken   (pred_taken),
        .pred_counter (pred_counter),
        .ready        (ready),
        .res_valid    (res_valid),
        .res_index    (res_index),
        .res_taken    (res_taken),
        .res_predicted(res_predicted),
        .mispredicts  (mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] idx;
        logic       taken;
        logic       predicted;
        logic [4:0] pidx;
        logic [1:0] exp_cnt;
        logic       exp_ptaken;
        logic [15:0] exp_miss;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{1'b1, 5'd3,  1'b1, 1'b1, 5'd3,  2'b10, 1'b1, 16'd0};
        vecs[1]  = '{1'b1, 5'd3,  1'b1, 1'b1, 5'd3,  2'b11, 1'b1, 16'd0};
        vecs[2]  = '{1'b1, 5'd7,  1'b1, 1'b1, 5'd7,  2'b10, 1'b1, 16'd0};
        vecs[3]  = '{1'b1, 5'd7,  1'b1, 1'b1, 5'd7,  2'b11, 1'b1, 16'd0};
        vecs[4]  = '{1'b1, 5'd7,  1'b1, 1'b1, 5'd7,  2'b11, 1'b1, 16'd0};
        vecs[5]  = '{1'b1, 5'd7,  1'b1, 1'b1, 5'd7,  2'b11, 1'b1, 16'd0};
        vecs[6]  = '{1'b1, 5'd7,  1'b1, 1'b1, 5'd7,  2'b11, 1'b1, 16'd0};
        vecs[7]  = '{1'b1, 5'd7,  1'b0, 1'b0, 5'd7,  2'b10, 1'b1, 16'd0};
        vecs[8]  = '{1'b1, 5'd9,  1'b0, 1'b0, 5'd9,  2'b00, 1'b0, 16'd0};
        vecs[9]  = '{1'b1, 5'd9,  1'b0, 1'b0, 5'd9,  2'b00, 1'b0, 16'd0};
        vecs[10] = '{1'b1, 5'd9,  1'b0, 1'b0, 5'd9,  2'b00, 1'b0, 16'd0};
        vecs[11] = '{1'b1, 5'd9,  1'b0, 1'b0, 5'd9,  2'b00, 1'b0, 16'd0};
        vecs[12] = '{1'b1, 5'd9,  1'b0, 1'b0, 5'd9,  2'b00, 1'b0, 16'd0};
        vecs[13] = '{1'b1, 5'd9,  1'b0, 1'b0, 5'd9,  2'b00, 1'b0, 16'd0};
        vecs[14] = '{1'b0, 5'd9,  1'b0, 1'b0, 5'd3,  2'b11, 1'b1, 16'd0};
        vecs[15] = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd7,  2'b10, 1'b1, 16'd0};
        vecs[16] = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  2'b01, 1'b0, 16'd0};
        vecs[17] = '{1'b1, 5'd20, 1'b1, 1'b0, 5'd20, 2'b10, 1'b1, 16'd1};
        vecs[18] = '{1'b1, 5'd20, 1'b0, 1'b1, 5'd20, 2'b01, 1'b0, 16'd2};
        vecs[19] = '{1'b1, 5'd20, 1'b1, 1'b1, 5'd20, 2'b10, 1'b1, 16'd2};
        vecs[20] = '{1'b1, 5'd20, 1'b0, 1'b0, 5'd20, 2'b01, 1'b0, 16'd2};
        vecs[21] = '{1'b1, 5'd20, 1'b1, 1'b0, 5'd20, 2'b10, 1'b1, 16'd3};
        vecs[22] = '{1'b1, 5'd9,  1'b1, 1'b1, 5'd3,  2'b11, 1'b1, 16'd3};
        vecs[23] = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd9,  2'b01, 1'b0, 16'd3};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 16'(ready), 16'd0);
        check("reset_miss", mispredicts, 16'd0);

        // Init sweep with resolves that must be ignored
        reset         = 1'b0;
        res_valid     = 1'b1;
        res_index     = 5'd5;
        res_taken     = 1'b1;
        res_predicted = 1'b0;
        pred_index    = 5'd5;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 10) begin
                check("init_pred_cnt", 16'(pred_counter), 16'd1);
                check("init_pred_taken", 16'(pred_taken), 16'd0);
                check("init_miss", mispredicts, 16'd0);
            end
            if (k == 31) check("ready_c31", 16'(ready), 16'd0);
            if (k == 32) check("ready_c32", 16'(ready), 16'd1);
        end
        res_valid = 1'b0;
        #1;
        check("post_init_miss", mispredicts, 16'd0);
        for (int i = 0; i < 32; i++) begin
            pred_index = 5'(i);
            #1;
            check("sweep_cnt", 16'(pred_counter), 16'd1);
            check("sweep_taken", 16'(pred_taken), 16'd0);
        end

        // Directed vectors
        for (int i = 0; i < 24; i++) begin
            res_valid     = vecs[i].valid;
            res_index     = vecs[i].idx;
            res_taken     = vecs[i].taken;
            res_predicted = vecs[i].predicted;
            pred_index    = vecs[i].pidx;
            step();
            check($sformatf("vec%0d_cnt", i), 16'(pred_counter), 16'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_taken", i), 16'(pred_taken), 16'(vecs[i].exp_ptaken));
            check($sformatf("vec%0d_miss", i), mispredicts, vecs[i].exp_miss);
        end

        // Mispredict counter saturation
        res_valid     = 1'b1;
        res_index     = 5'd21;
        res_taken     = 1'b1;
        res_predicted = 1'b0;
        repeat (65531) @(posedge clk);
        #1;
        check("miss_fffe", mispredicts, 16'hFFFE);
        step();
        check("miss_ffff_a", mispredicts, 16'hFFFF);
        step();
        check("miss_ffff_b", mispredicts, 16'hFFFF);

        // Reset while a write is pending
        res_index  = 5'd12;
        pred_index = 5'd12;
        step();
        res_valid = 1'b0;
        check("pend12_cnt", 16'(pred_counter), 16'd2);
        reset = 1'b1;
        #1;
        check("rst_ready", 16'(ready), 16'd0);
        check("rst_miss", mispredicts, 16'd0);
        step();
        step();
        reset = 1'b0;
        wait_ready(cyc);
        check("reinit_cycles", 16'(cyc), 16'd32);
        check("reinit_ready", 16'(ready), 16'd1);
        check("reinit_cnt12", 16'(pred_counter), 16'd1);
        check("reinit_miss", mispredicts, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_pattern_table.md
Name: branch_pattern_table

Overview:
Second level of the local two-level branch predictor. It consumes the 5-bit per-branch history produced by the branch history table and returns a taken/not-taken prediction from a 2-bit saturating counter indexed by that history. It is trained by the resolve interface from the execute stage, and it counts mispredictions for performance monitoring. It sits between the branch history table (fetch side) and the branch resolution logic (execute side).

Parameters:
INDEX_WIDTH, 5, history/index width; matches lc3b_p_index (32 entries).
COUNTER_INIT, 2'b01, value written to every counter during init (weakly not-taken).
MISS_WIDTH, 16, width of the mispredict counter.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
pred_index  input  lc3b_p_index  history from branch history table; lookup address
pred_taken  output  1  prediction = MSB of effective counter at pred_index
pred_counter  output  2  effective counter value at pred_index
ready  output  1  table initialised, resolves accepted
res_valid  input  1  resolve update strobe (one branch per cycle)
res_index  input  lc3b_p_index  history the resolved branch was predicted with
res_taken  input  1  actual branch outcome
res_predicted  input  1  prediction that was used for this branch
mispredicts  output  MISS_WIDTH  saturating count of resolves with res_taken != res_predicted

Behaviour:
- Storage: 32 x 2-bit counters, register-based, no reset on the array itself; contents are set by the init sweep.
- FSM states: INIT, RUN.
- Async reset effects: state=INIT, init_ptr=0, pending_valid=0, mispredicts=0, ready=0.
- INIT:
  - Each cycle, table[init_ptr] <= COUNTER_INIT and init_ptr increments.
  - When init_ptr==31 is written, next state is RUN.
  - ready=1 starting exactly 32 cycles after reset deasserts.
  - res_valid is ignored: no table change, no mispredict count.
  - pred_counter=COUNTER_INIT and pred_taken=COUNTER_INIT[1] regardless of pred_index.
- RUN, update pipeline (2 stages):
  - Cycle N (res_valid=1): read the effective counter at res_index. If pending_valid and pending_index==res_index, use pending_value instead of the array. Compute the next value: taken adds 1, saturating at 2'b11; not-taken subtracts 1, saturating at 2'b00. Register {pending_valid=1, pending_index, pending_value}.
  - Cycle N+1: table[pending_index] <= pending_value. pending_valid clears unless a new resolve arrives.
- Back-to-back resolves to the same index chain correctly through the bypass; no update is lost.
- Lookup: combinational. If pending_valid and pending_index==pred_index, output pending_value; otherwise output table[pred_index]. A resolve accepted in cycle N is therefore visible to lookups from cycle N+1.
- Mispredicts: in any RUN cycle with res_valid=1 and res_taken!=res_predicted, increment by 1, saturating at all-ones (no wrap).
- Reset during INIT restarts the sweep at index 0. Reset during RUN discards any pending write and re-runs INIT.

Test Plan:
- Deassert reset, hold res_valid=0 -> ready rises on cycle 32 after deassert; sweeping pred_index 0..31 gives pred_counter=01, pred_taken=0 for all.
- After ready: res_valid on two consecutive cycles, res_index=3, res_taken=1, pred_index=3 -> pred_counter reads 10 the cycle after the first resolve and 11 after the second; pred_taken=1.
- Saturation: five taken resolves to index 7, then one not-taken -> counter 11, 11, then 10; pred_taken stays 1. Six not-taken to index 9 -> counter reaches 00 and holds.
- Pulse res_valid with res_taken=1 and res_predicted=0 during INIT -> after ready, index counter is 01 and mispredicts=0.
- Five resolves with (taken,predicted) = (1,0),(0,1),(1,1),(0,0),(1,0) -> mispredicts=3. Force the counter to 16'hFFFE, then two mismatches -> counter holds at 16'hFFFF.
- Resolve taken to index 12, then assert reset the next cycle while the pending write is outstanding -> after re-init, index 12 reads 01 and mispredicts=0.
